muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative multiply/divide sequencer for the RV64M ops beside the single-cycle ALU in execute.
//  Accepts one op from execute, runs a shift-add multiply or restoring divide over XLEN/32 cycles,
//  holds the result until execute consumes it. busy drives the pipeline stall.
// PARAMETERS
//  XLEN   64  operand/result width (word_t)
//  CNT_W  7   iteration counter width; must hold XLEN
// PORTS
//  clk        in   1     clock
//  reset      in   1     synchronous, active-high reset
//  in_valid   in   1     execute presents an M-op
//  in_ready   out  1     sequencer can accept (IDLE only)
//  op         in   3     0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5-7 decode as MUL
//  is_word    in   1     W variant (MULW/DIVW/DIVUW/REMW/REMUW)
//  srca       in   XLEN  rs1 value
//  srcb       in   XLEN  rs2 value
//  flush      in   1     kill in-flight op (branch mispredict / trap)
//  out_valid  out  1     result available
//  out_ready  in   1     execute consumes result
//  result     out  XLEN  final value
//  busy       out  1     ~IDLE; stall request to hazard unit
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0.
//  FSM IDLE->CALC->DONE->IDLE:
//   IDLE: in_ready=1. in_valid&&in_ready latches op, is_word, operands, next state CALC.
//     Counter loads N = 32 if is_word, else XLEN.
//   CALC: one iteration per cycle; counter decrements; when counter==1 next state DONE.
//   DONE: out_valid=1, result stable; out_valid&&out_ready -> IDLE. Hold while !out_ready.
//  Latency: accept edge to out_valid = N+1 cycles (65 for 64-bit, 33 for W ops).
//  A new op is accepted in IDLE only, never in the same cycle as the result handshake.
//  Operand prep:
//   W ops use the low 32 bits. Signed ops sign-extend; DIVU/REMU zero-extend.
//   Signed div/rem: divide magnitudes, then negate. Quotient sign = sa^sb; remainder sign = sa.
//  Result width:
//   MUL: low XLEN bits of the product. MULW: product[31:0] sign-extended to 64 bits.
//   All W results: sign-extend bit 31.
//  Special cases (RISC-V spec), same N+1 latency unless the early-out feature is built:
//   divisor==0: quotient = all ones; remainder = dividend (W: sign-extended low 32 bits).
//   signed overflow (min / -1): quotient = min (W: 0xFFFFFFFF80000000); remainder = 0.
//  flush: highest priority in every state except reset. Next state IDLE; out_valid=0 next cycle.
//   A same-cycle in_valid is ignored. A flush in DONE drops the result even if out_ready=1.
//  reset mid-CALC: returns to reset values next cycle; no partial result is exposed.
//  busy = (state!=IDLE). in_ready = (state==IDLE).
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   In IDLE, detect divisor==0, signed overflow, or a multiply with either operand==0.
//   These go directly IDLE->DONE with the special-case or zero result; latency 1 cycle.
//  Undefined: no early-out logic; every op takes the full N+1 cycles.
// TESTING
//  1 MUL srca=7 srcb=-3, out_ready=1:
//    out_valid in cycle 65 after accept, result=0xFFFFFFFFFFFFFFEB, then IDLE.
//  2 DIVW srca=0x00000000FFFFFFF9 (-7) srcb=2:
//    result=0xFFFFFFFFFFFFFFFD at 33 cycles. Repeat as REMW -> 0xFFFFFFFFFFFFFFFF.
//  3 DIVU srcb=0, srca=5:
//    result=0xFFFFFFFFFFFFFFFF. REM with srcb=0 -> 5.
//    Check latency 65 without MULDIV_EARLY_OUT_EN, 1 with it.
//  4 DIV srca=0x8000000000000000 srcb=-1:
//    result=0x8000000000000000. REM of the same operands -> 0.
//  5 DONE held with out_ready=0 for 10 cycles:
//    result stable, busy=1, in_valid ignored. out_ready=1 -> IDLE next cycle.
//  6 flush asserted at CALC cycle 20 with in_valid=1:
//    IDLE next cycle, out_valid never rises. The following accepted op completes correctly.

Source files
------------

// File: rtl/muldiv_if.sv
// Execute <-> M-op sequencer handshake: request side (op/operands/flush) and result side.
// master = execute stage, slave = muldiv_seq.
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            is_word;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, is_word, srca, srcb, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, is_word, srca, srcb, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV64M sequencer: shift-add multiply / restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish in 1 cycle.
//  state  | meaning
//  S_IDLE | ready for a new op
//  S_CALC | iterating, cnt counts remaining steps
//  S_DONE | result held until out_ready
module muldiv_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    typedef logic [XLEN-1:0] word_t;

    function automatic word_t wfix(input logic w, input word_t x);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_div_q, is_rem_q, word_q, neg_q, div0_q;
    word_t            a_q, b_q, dvd_q, result_q;
    logic [XLEN:0]    acc_q;

    logic  is_div, is_rem, is_sgn, sa, sb;
    word_t ea, eb, mag_a, mag_b, a_init, b_init;

    always_comb begin
        is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU) || (bus.op == OP_REM) || (bus.op == OP_REMU);
        is_rem = (bus.op == OP_REM) || (bus.op == OP_REMU);
        is_sgn = (bus.op == OP_DIV) || (bus.op == OP_REM);
        if (bus.is_word) begin
            ea = is_sgn ? {{(XLEN-32){bus.srca[31]}}, bus.srca[31:0]} : {{(XLEN-32){1'b0}}, bus.srca[31:0]};
            eb = is_sgn ? {{(XLEN-32){bus.srcb[31]}}, bus.srcb[31:0]} : {{(XLEN-32){1'b0}}, bus.srcb[31:0]};
        end else begin
            ea = bus.srca;
            eb = bus.srcb;
        end
        sa    = is_sgn & ea[XLEN-1];
        sb    = is_sgn & eb[XLEN-1];
        mag_a = sa ? -ea : ea;
        mag_b = sb ? -eb : eb;
        // W divides run 32 steps, so the dividend starts in the top half of the shifter
        if (is_div) begin
            a_init = bus.is_word ? (mag_a << (XLEN-32)) : mag_a;
            b_init = mag_b;
        end else begin
            a_init = ea;
            b_init = eb;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic  eo_hit;
    word_t eo_res, min_val;
    always_comb begin
        eo_hit  = 1'b0;
        eo_res  = '0;
        min_val = bus.is_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        if (is_div) begin
            if (eb == '0) begin
                eo_hit = 1'b1;
                eo_res = is_rem ? wfix(bus.is_word, ea) : '1;
            end else if (is_sgn && (ea == min_val) && (eb == '1)) begin
                eo_hit = 1'b1;
                eo_res = is_rem ? '0 : ea;
            end
        end else if ((ea == '0) || (eb == '0)) begin
            eo_hit = 1'b1;
        end
    end
`endif

    logic [XLEN:0] rs, diff, acc_n;
    word_t         a_n, b_n, mul_add, raw, fin;

    always_comb begin
        rs      = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        diff    = rs - {1'b0, b_q};
        mul_add = b_q[0] ? a_q : '0;
        if (is_div_q) begin
            acc_n = diff[XLEN] ? rs : diff;
            a_n   = {a_q[XLEN-2:0], ~diff[XLEN]};
            b_n   = b_q;
        end else begin
            acc_n = acc_q + {1'b0, mul_add};
            a_n   = a_q << 1;
            b_n   = b_q >> 1;
        end
        if (!is_div_q)     raw = acc_n[XLEN-1:0];
        else if (div0_q)   raw = is_rem_q ? dvd_q : '1;
        else if (is_rem_q) raw = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        else               raw = neg_q ? -a_n : a_n;
        fin = wfix(word_q, raw);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result_q <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            acc_q    <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    is_div_q <= is_div;
                    is_rem_q <= is_rem;
                    word_q   <= bus.is_word;
                    neg_q    <= is_rem ? sa : (sa ^ sb);
                    div0_q   <= (eb == '0);
                    a_q      <= a_init;
                    b_q      <= b_init;
                    dvd_q    <= ea;
                    acc_q    <= '0;
                    cnt      <= bus.is_word ? CNT_W'(32) : CNT_W'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
                    if (eo_hit) begin
                        result_q <= eo_res;
                        state    <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
`else
                    state <= S_CALC;
`endif
                end
                S_CALC: begin
                    a_q   <= a_n;
                    b_q   <= b_n;
                    acc_q <= acc_n;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= S_DONE;
                        result_q <= fin;
                    end
                end
                S_DONE: if (bus.out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for results/latency, plus hold, flush and reset sequences.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.XLEN(64)) bus_if ();
    muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SP  = 1;
    localparam int LAT_SPW = 1;
`else
    localparam int LAT_SP  = 65;
    localparam int LAT_SPW = 33;
`endif

    typedef struct {
        logic [2:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic ordy, output int lat);
        bus_if.op        = op;
        bus_if.is_word   = w;
        bus_if.srca      = a;
        bus_if.srcb      = b;
        bus_if.out_ready = ordy;
        bus_if.in_valid  = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
            lat++;
        end while (!bus_if.out_valid && lat < 200);
    endtask

    initial begin
        int lat;
        logic seen;

        vecs[0]  = '{3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB, 65};
        vecs[1]  = '{3'd1, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 33};
        vecs[2]  = '{3'd3, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33};
        vecs[3]  = '{3'd2, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, LAT_SP};
        vecs[4]  = '{3'd3, 1'b0, 64'd5, 64'd0, 64'd5, LAT_SP};
        vecs[5]  = '{3'd1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, LAT_SP};
        vecs[6]  = '{3'd3, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, LAT_SP};
        vecs[7]  = '{3'd0, 1'b1, 64'h123456787FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 33};
        vecs[8]  = '{3'd2, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[9]  = '{3'd4, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        vecs[10] = '{3'd1, 1'b0, -64'sd100, 64'd7, 64'hFFFFFFFFFFFFFFF2, 65};
        vecs[11] = '{3'd3, 1'b0, -64'sd100, 64'd7, 64'hFFFFFFFFFFFFFFFE, 65};
        vecs[12] = '{3'd2, 1'b1, 64'h00000000FFFFFFF0, 64'h10, 64'h000000000FFFFFFF, 33};
        vecs[13] = '{3'd5, 1'b0, 64'd6, 64'd7, 64'd42, 65};
        vecs[14] = '{3'd3, 1'b1, 64'h0000000080000005, 64'hABCD000000000000, 64'hFFFFFFFF80000005, LAT_SPW};
        vecs[15] = '{3'd1, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, LAT_SPW};

        reset            = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.op        = 3'd0;
        bus_if.is_word   = 1'b0;
        bus_if.srca      = '0;
        bus_if.srcb      = '0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        check("rst_result", bus_if.result, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 1'b1, lat);
            check($sformatf("vec%0d_result", i), bus_if.result, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle_after", i), {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'd2);
        end

        // result held while execute is stalled; new requests must be ignored
        run_op(3'd2, 1'b0, 64'd100, 64'd7, 1'b0, lat);
        check("hold_latency", 64'(lat), 64'd65);
        bus_if.op = 3'd0; bus_if.srca = 64'd3; bus_if.srcb = 64'd3; bus_if.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_result", bus_if.result, 64'd14);
            check("hold_busy_valid", {62'd0, bus_if.busy, bus_if.out_valid}, 64'd3);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release", {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'd2);

        // flush mid-CALC with a competing request
        bus_if.op = 3'd0; bus_if.is_word = 1'b0; bus_if.srca = 64'd7; bus_if.srcb = -64'sd3;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        bus_if.flush = 1'b1; bus_if.in_valid = 1'b1;
        bus_if.op = 3'd2; bus_if.srca = 64'd5; bus_if.srcb = 64'd0;
        @(posedge clk); #1;
        bus_if.flush = 1'b0; bus_if.in_valid = 1'b0;
        check("flush_idle", {62'd0, bus_if.in_ready, bus_if.busy}, 64'd2);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) seen = 1'b1;
        end
        check("flush_no_valid", {63'd0, seen}, 64'd0);
        run_op(3'd0, 1'b0, 64'd7, -64'sd3, 1'b1, lat);
        check("post_flush_result", bus_if.result, 64'hFFFFFFFFFFFFFFEB);
        check("post_flush_latency", 64'(lat), 64'd65);
        @(posedge clk); #1;

        // flush in DONE drops the result even with out_ready high
        run_op(3'd4, 1'b0, 64'd100, 64'd7, 1'b0, lat);
        check("done_flush_pre", {63'd0, bus_if.out_valid}, 64'd1);
        bus_if.flush = 1'b1; bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.flush = 1'b0;
        check("done_flush_idle", {62'd0, bus_if.in_ready, bus_if.out_valid}, 64'd2);

        // reset mid-CALC
        run_op(3'd0, 1'b0, 64'd9, 64'd9, 1'b1, lat);
        @(posedge clk); #1;
        bus_if.op = 3'd1; bus_if.srca = 64'd50; bus_if.srcb = 64'd5; bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_state", {61'd0, bus_if.in_ready, bus_if.busy, bus_if.out_valid}, 64'd4);
        check("midreset_result", bus_if.result, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) seen = 1'b1;
        end
        check("midreset_no_valid", {63'd0, seen}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
